// File: rtl/ps2_rx_ctrl_if.sv
// Scan-code handshake between the PS/2 receive controller and the decoder.
// The controller drives the FIFO head; the decoder returns code_ready.
interface ps2_rx_ctrl_if;
   logic [7:0] code;
   logic       is_break;
   logic       is_ext;
   logic       code_valid;
   logic       code_ready;

   modport master (output code, output is_break, output is_ext, output code_valid,
                   input  code_ready);
   modport slave  (input  code, input  is_break, input  is_ext, input  code_valid,
                   output code_ready);
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive path: synchronise and filter the PS/2 lines, frame and check
// 11-bit packets, fold E0/F0 prefixes into flags and queue scan codes for the decoder.
module ps2_rx_ctrl #(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_pc2,
   input  logic          data_pc2,
   ps2_rx_ctrl_if.master code_if,
   output logic          frame_err,
   output logic          overflow
);
   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 10;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d, filt_prev_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic          err_q, err_d, ovf_q, ovf_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic          fall_c, push_c, pop_c, full_c, wr_en_c;

   assign fall_c = filt_prev_q & ~filt_q;

   // Next-state logic: glitch filter, framing FSM with timeout, prefix flags and FIFO control
   always_comb begin
      filt_d  = filt_q;
      fcnt_d  = fcnt_q;
      state_d = state_q;
      bcnt_d  = bcnt_q;
      sh_d    = sh_q;
      par_d   = par_q;
      to_d    = to_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      err_d   = 1'b0;
      push_c  = 1'b0;

      if (clk_s2_q == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
         filt_d = clk_s2_q;
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + FW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (fall_c && !dat_s2_q) begin
               state_d = S_DATA;
               bcnt_d  = 3'd0;
            end
         end
         S_DATA: begin
            if (fall_c) begin
               sh_d   = {dat_s2_q, sh_q[7:1]};
               bcnt_d = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall_c) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         default: begin
            if (fall_c) begin
               state_d = S_IDLE;
               if (dat_s2_q && (^{sh_q, par_q})) begin
                  if (sh_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (sh_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else begin
                     push_c = 1'b1;
                     ext_d  = 1'b0;
                     brk_d  = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         end
      endcase

      // A stalled frame is abandoned once the keyboard clock stops for too long
      if (state_q == S_IDLE || fall_c) begin
         to_d = '0;
      end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
         to_d    = '0;
         state_d = S_IDLE;
         err_d   = 1'b1;
         ext_d   = 1'b0;
         brk_d   = 1'b0;
      end else begin
         to_d = to_q + TW'(1);
      end

      pop_c   = (cnt_q != '0) && code_if.code_ready;
      full_c  = (cnt_q == CW'(FIFO_DEPTH));
      wr_en_c = push_c && (!full_c || pop_c);
      ovf_d   = ovf_q | (push_c && full_c && !pop_c);
      wr_d    = wr_en_c ? wr_q + AW'(1) : wr_q;
      rd_d    = pop_c ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q + CW'(wr_en_c) - CW'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
         state_q     <= S_IDLE;
         bcnt_q      <= '0;
         sh_q        <= '0;
         par_q       <= 1'b0;
         to_q        <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         clk_s1_q    <= clk_pc2;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= data_pc2;
         dat_s2_q    <= dat_s1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         fcnt_q      <= fcnt_d;
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         sh_q        <= sh_d;
         par_q       <= par_d;
         to_q        <= to_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else if (wr_en_c) begin
         mem_q[wr_q] <= {ext_q, brk_q, sh_q};
      end
   end

   assign code_if.code       = mem_q[rd_q][7:0];
   assign code_if.is_break   = mem_q[rd_q][8];
   assign code_if.is_ext     = mem_q[rd_q][9];
   assign code_if.code_valid = (cnt_q != '0);
   assign frame_err          = err_q;
   assign overflow           = ovf_q;
endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Sequences the PS/2 keyboard receive path. It synchronises and filters clk_pc2/data_pc2, frames each 11-bit PS/2 packet, checks parity, stop bit and timeout, and folds E0/F0 prefix bytes into flags. Completed scan codes go into a small FIFO drained by the scan-code decoder over a valid/ready handshake. It replaces the ad-hoc one-shot strobe logic between the receiver and the decoder.

Parameters:
FILT_LEN, 8, consecutive stable clk cycles required before the filtered PS/2 clock changes level
TIMEOUT_CYC, 100000, clk cycles without a PS/2 falling edge that abort a partial frame (1 ms at 100 MHz)
FIFO_DEPTH, 4, scan-code FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
clk_pc2  in  1  raw PS/2 clock from the keyboard, asynchronous
data_pc2  in  1  raw PS/2 data from the keyboard, asynchronous
code  out  8  scan code at the FIFO head
is_break  out  1  head entry was preceded by F0
is_ext  out  1  head entry was preceded by E0
code_valid  out  1  FIFO not empty
code_ready  in  1  decoder accepts the head entry
frame_err  out  1  one-cycle pulse on a parity, start/stop or timeout error
overflow  out  1  sticky; a completed code was dropped because the FIFO was full

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset state:
  - all outputs 0; FSM in IDLE; FIFO empty
  - E0/F0 pending flags clear; timeout counter 0
  - synchronisers and filtered clock preset to 1, so no false edge follows reset
- Input conditioning:
  - 2-FF synchroniser on each raw input
  - filtered clock takes the synced level only after FILT_LEN consecutive equal samples
  - fall = registered 1->0 transition of the filtered clock; data is sampled from the synced data_pc2 in the fall cycle
  - clock glitches shorter than FILT_LEN cycles produce no fall
- Framing FSM, evaluated on each fall:
  - IDLE: data==0 -> DATA with bit count 0; data==1 -> stay in IDLE (spurious edge, no error)
  - DATA: shift the bit in LSB first; after the 8th bit -> PARITY
  - PARITY: capture the bit -> STOP
  - STOP: if stop==1 and the 8 data bits plus parity hold an odd number of ones, the frame is good; otherwise pulse frame_err. Either way -> IDLE.
- Timeout:
  - counter clears on every fall and whenever the FSM is in IDLE
  - in a non-IDLE state, reaching TIMEOUT_CYC -> IDLE, partial byte discarded, frame_err pulses for one cycle, pending flags cleared
- Prefix handling for good bytes:
  - 0xE0 sets ext_pending; 0xF0 sets brk_pending; neither is pushed
  - any other byte pushes {ext_pending, brk_pending, byte}, then both flags clear
  - a parity/stop error clears both flags
- FIFO:
  - first-word-fall-through; head entry drives code/is_ext/is_break
  - pop when code_valid && code_ready
  - push registers at the clk edge ending the good-STOP fall cycle; with the FIFO empty, code_valid is 1 on the following cycle
  - push while full with no pop: entry dropped, overflow set to 1 and held until rst
  - push and pop in the same cycle while full: both happen, no overflow
  - pop while empty: ignored
  - outputs stay stable while code_valid && !code_ready
- Reset mid-frame: frame abandoned, no frame_err, state as at reset.
- frame_err and a push never come from the same frame.

Test Plan:
1. Frame for 0x1C (parity 0, stop 1), with a 3-cycle low glitch on clk_pc2 before the start bit, code_ready=1 -> one entry: code=0x1C, is_break=0, is_ext=0; code_valid high for exactly 1 cycle; no frame_err.
2. Frames F0 then 1C, code_ready=0 -> exactly one entry: code=0x1C, is_break=1, is_ext=0. code_valid stays high and outputs stay stable until code_ready=1, then code_valid=0.
3. Frames E0, F0, 74 -> one entry: code=0x74, is_ext=1, is_break=1. Next frame 74 -> code=0x74, both flags 0.
4. Frame 0x1C with parity bit 1 -> frame_err pulses once, no entry. Frame 0x1C with stop bit 0 -> same result. A following good 0x1C -> accepted normally.
5. Start bit plus 4 data bits, then clock held high for TIMEOUT_CYC+10 cycles -> frame_err pulses once, FSM back in IDLE. Following frame 0x29 -> code=0x29.
6. FIFO_DEPTH=4, code_ready=0, frames 16,1E,26,25,2E -> overflow=1. Draining yields 16,1E,26,25 in order, then code_valid=0. overflow stays 1 until rst.
